// File: rtl/tpu_tile_sched.sv
// ---------------------------------------------------------------------------
// tpu_tile_sched
//
// Tile scheduler for the 4x4 int8 systolic matmul engine. A job (K, M, N)
// is walked as ceil(M/4) x ceil(N/4) output tiles, nt inner and mt outer.
// For each tile the scheduler clears the PE accumulators, streams K A/B
// buffer read addresses, waits for the array pipeline to flush, then
// drains the four accumulator rows into the C buffer.
//
// Optional feature (compile-time macro TILE_SCHED_PERF_EN):
//   defined   -> perf_cycles counts busy cycles of the most recent job,
//                saturating at 2^32-1
//   undefined -> perf_cycles is tied to 0
//
// Parameters:
//   PIPE_LAT  cycles from the last array feed until accumulators are final
//   IDX_W     width of A/B/C buffer indices
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   in_valid         job start pulse; K/M/N sampled on the same edge
//   K, M, N          reduction length, output rows, output columns
//   busy, done       job in progress / one-cycle end-of-job pulse
//   A_index          A buffer read address
//   B_index          B buffer read address
//   arr_clear        zero the PE accumulators
//   arr_feed         A/B buffer data valid this cycle (one cycle after index)
//   arr_row_sel      accumulator row muxed onto the C write data
//   C_wr_en, C_index C buffer write strobe and address
//   perf_cycles      busy-cycle count
// ---------------------------------------------------------------------------
module tpu_tile_sched #(
  parameter int PIPE_LAT = 7,
  parameter int IDX_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       K,
  input  logic [7:0]       M,
  input  logic [7:0]       N,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] A_index,
  output logic [IDX_W-1:0] B_index,
  output logic             arr_clear,
  output logic             arr_feed,
  output logic [1:0]       arr_row_sel,
  output logic             C_wr_en,
  output logic [IDX_W-1:0] C_index,
  output logic [31:0]      perf_cycles
);

  localparam int WAIT_W = (PIPE_LAT < 1) ? 1 : $clog2(PIPE_LAT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(PIPE_LAT);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FEED, S_WAIT, S_DRAIN, S_NEXT, S_DONE
  } state_t;

  state_t st, st_n;

  // Job parameters latched on accept
  logic [7:0]       k_len, k_len_n, m_len, m_len_n;
  logic [5:0]       mt_last, mt_last_n, nt_last, nt_last_n;

  // Walk counters
  logic [7:0]       k_cnt, k_cnt_n;
  logic [WAIT_W-1:0] w_cnt, w_cnt_n;
  logic [1:0]       r_cnt, r_cnt_n;
  logic [5:0]       mt, mt_n, nt, nt_n;

  // Running bases replace the mt*K, nt*K, nt*M and mt*4 products
  logic [IDX_W-1:0] a_base, a_base_n, b_base, b_base_n;
  logic [IDX_W-1:0] c_base, c_base_n, m_base, m_base_n;
  logic [IDX_W-1:0] row_m;

  // Registered outputs, computed from the next state
  logic             busy_q, busy_n, done_q, done_n, clr_q, clr_n;
  logic             wr_q, wr_n;
  logic [1:0]       rsel_q, rsel_n;
  logic [IDX_W-1:0] a_q, a_n, b_q, b_n, c_q, c_n;
  logic             feed_vld_p1;

  always_comb begin
    st_n      = st;
    k_len_n   = k_len;
    m_len_n   = m_len;
    mt_last_n = mt_last;
    nt_last_n = nt_last;
    k_cnt_n   = k_cnt;
    w_cnt_n   = w_cnt;
    r_cnt_n   = r_cnt;
    mt_n      = mt;
    nt_n      = nt;
    a_base_n  = a_base;
    b_base_n  = b_base;
    c_base_n  = c_base;
    m_base_n  = m_base;

    unique case (st)
      S_IDLE: begin
        if (in_valid) begin
          k_len_n   = K;
          m_len_n   = M;
          mt_last_n = 6'((M - 8'd1) >> 2);
          nt_last_n = 6'((N - 8'd1) >> 2);
          mt_n      = '0;
          nt_n      = '0;
          a_base_n  = '0;
          b_base_n  = '0;
          c_base_n  = '0;
          m_base_n  = '0;
          st_n      = (K != 8'd0 && M != 8'd0 && N != 8'd0) ? S_CLEAR : S_DONE;
        end
      end
      S_CLEAR: begin
        k_cnt_n = '0;
        st_n    = S_FEED;
      end
      S_FEED: begin
        if (k_cnt == k_len - 8'd1) begin
          w_cnt_n = '0;
          st_n    = S_WAIT;
        end else begin
          k_cnt_n = k_cnt + 8'd1;
        end
      end
      S_WAIT: begin
        if (w_cnt == WAIT_LAST) begin
          r_cnt_n = '0;
          st_n    = S_DRAIN;
        end else begin
          w_cnt_n = w_cnt + 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_cnt == 2'd3) st_n = S_NEXT;
        else               r_cnt_n = r_cnt + 2'd1;
      end
      S_NEXT: begin
        if (nt == nt_last) begin
          nt_n     = '0;
          b_base_n = '0;
          c_base_n = '0;
          if (mt == mt_last) begin
            st_n = S_DONE;
          end else begin
            mt_n     = mt + 6'd1;
            a_base_n = a_base + IDX_W'(k_len);
            m_base_n = m_base + IDX_W'(4);
            st_n     = S_CLEAR;
          end
        end else begin
          nt_n     = nt + 6'd1;
          b_base_n = b_base + IDX_W'(k_len);
          c_base_n = c_base + IDX_W'(m_len);
          st_n     = S_CLEAR;
        end
      end
      S_DONE:  st_n = S_IDLE;
      default: st_n = S_IDLE;
    endcase

    // Output values for the cycle spent in st_n
    busy_n = (st_n == S_CLEAR) || (st_n == S_FEED) || (st_n == S_WAIT) ||
             (st_n == S_DRAIN) || (st_n == S_NEXT);
    done_n = (st_n == S_DONE);
    clr_n  = (st_n == S_CLEAR);
    a_n    = a_q;
    b_n    = b_q;
    c_n    = c_q;
    wr_n   = 1'b0;
    rsel_n = 2'd0;
    row_m  = m_base_n + IDX_W'(r_cnt_n);
    if (st_n == S_FEED) begin
      a_n = a_base_n + IDX_W'(k_cnt_n);
      b_n = b_base_n + IDX_W'(k_cnt_n);
    end
    if (st_n == S_DRAIN) begin
      rsel_n = r_cnt_n;
      c_n    = c_base_n + row_m;
      wr_n   = (row_m < IDX_W'(m_len_n));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st          <= S_IDLE;
      k_len       <= '0;
      m_len       <= '0;
      mt_last     <= '0;
      nt_last     <= '0;
      k_cnt       <= '0;
      w_cnt       <= '0;
      r_cnt       <= '0;
      mt          <= '0;
      nt          <= '0;
      a_base      <= '0;
      b_base      <= '0;
      c_base      <= '0;
      m_base      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      clr_q       <= 1'b0;
      wr_q        <= 1'b0;
      rsel_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      feed_vld_p1 <= 1'b0;
    end else begin
      st          <= st_n;
      k_len       <= k_len_n;
      m_len       <= m_len_n;
      mt_last     <= mt_last_n;
      nt_last     <= nt_last_n;
      k_cnt       <= k_cnt_n;
      w_cnt       <= w_cnt_n;
      r_cnt       <= r_cnt_n;
      mt          <= mt_n;
      nt          <= nt_n;
      a_base      <= a_base_n;
      b_base      <= b_base_n;
      c_base      <= c_base_n;
      m_base      <= m_base_n;
      busy_q      <= busy_n;
      done_q      <= done_n;
      clr_q       <= clr_n;
      wr_q        <= wr_n;
      rsel_q      <= rsel_n;
      a_q         <= a_n;
      b_q         <= b_n;
      c_q         <= c_n;
      // Stage p1: buffer data arrives one cycle after the FEED address
      feed_vld_p1 <= (st == S_FEED);
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign arr_clear   = clr_q;
  assign arr_feed    = feed_vld_p1;
  assign arr_row_sel = rsel_q;
  assign C_wr_en     = wr_q;
  assign A_index     = a_q;
  assign B_index     = b_q;
  assign C_index     = c_q;

`ifdef TILE_SCHED_PERF_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] perf_q;
  logic        job_accept;

  assign job_accept = (st == S_IDLE) && in_valid;

  always_ff @(posedge clk) begin
    if (!rst_n)          perf_q <= '0;
    else if (job_accept) perf_q <= '0;
    else if (busy_q)     perf_q <= sat_inc32(perf_q);
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_tpu_tile_sched.sv
// ---------------------------------------------------------------------------
// tb_tpu_tile_sched
//
// Directed bench for tpu_tile_sched. Each job is captured cycle by cycle:
// A/B indices that were presented one cycle before arr_feed, C writes with
// their row select, busy/clear/done counts and perf_cycles, then each test
// task compares the capture against hand-computed values.
// ---------------------------------------------------------------------------
module tb_tpu_tile_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  K = '0, M = '0, N = '0;
  logic        busy, done, arr_clear, arr_feed, C_wr_en;
  logic [15:0] A_index, B_index, C_index;
  logic [1:0]  arr_row_sel;
  logic [31:0] perf_cycles;

  int n_vec = 0;
  int n_err = 0;

  int qa[$], qb[$], qc[$], qrs[$];
  int busy_cnt, done_cnt, clr_cnt, done_idx;
  logic [31:0] perf_at_done, perf_end;

`ifdef TILE_SCHED_PERF_EN
  localparam logic [31:0] PERF_S1 = 32'd16;
  localparam logic [31:0] PERF_S2 = 32'd68;
`else
  localparam logic [31:0] PERF_S1 = 32'd0;
  localparam logic [31:0] PERF_S2 = 32'd0;
`endif

  tpu_tile_sched #(.PIPE_LAT(7), .IDX_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .K(K), .M(M), .N(N),
    .busy(busy), .done(done),
    .A_index(A_index), .B_index(B_index),
    .arr_clear(arr_clear), .arr_feed(arr_feed), .arr_row_sel(arr_row_sel),
    .C_wr_en(C_wr_en), .C_index(C_index), .perf_cycles(perf_cycles)
  );

  always #5 clk = ~clk;

  // Start a job and record its activity until 20 cycles past done.
  // inj_at >= 0 pulses in_valid (with K=9) after that sample index.
  task automatic run_job(input logic [7:0] k, input logic [7:0] m,
                         input logic [7:0] n, input int inj_at);
    int prev_a, prev_b;
    qa.delete(); qb.delete(); qc.delete(); qrs.delete();
    busy_cnt = 0; done_cnt = 0; clr_cnt = 0; done_idx = -1;
    perf_at_done = '1; perf_end = '1;
    prev_a = 0; prev_b = 0;
    @(negedge clk);
    K = k; M = m; N = n; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (arr_feed) begin qa.push_back(prev_a); qb.push_back(prev_b); end
      prev_a = int'(A_index);
      prev_b = int'(B_index);
      if (C_wr_en) begin qc.push_back(int'(C_index)); qrs.push_back(int'(arr_row_sel)); end
      if (busy) busy_cnt++;
      if (arr_clear) clr_cnt++;
      if (done) begin
        done_cnt++;
        if (done_idx < 0) begin done_idx = i; perf_at_done = perf_cycles; end
      end
      if (i == inj_at) begin in_valid = 1'b1; K = 8'd9; end
      else in_valid = 1'b0;
      if (done_idx >= 0 && i >= done_idx + 20) break;
      @(negedge clk);
    end
    in_valid = 1'b0;
    perf_end = perf_cycles;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy, done, arr_clear, arr_feed, C_wr_en, arr_row_sel} !== 7'd0 ||
        A_index !== 16'd0 || B_index !== 16'd0 || C_index !== 16'd0 ||
        perf_cycles !== 32'd0) begin
      n_err++;
      $display("FAIL reset_outputs: busy=%b done=%b A=%0d B=%0d C=%0d perf=%0d, required all 0",
               busy, done, A_index, B_index, C_index, perf_cycles);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Shared body for the single-tile job (also used after an ignored in_valid)
  task automatic test_single_tile(input int inj_at, input string tag);
    int ea[2] = '{0, 1};
    run_job(8'd2, 8'd4, 8'd4, inj_at);
    n_vec++;
    if (done_idx != 16) begin
      n_err++; $display("FAIL %s_done_idx: got %0d, required 16", tag, done_idx);
    end
    n_vec++;
    if (busy_cnt != 16 || done_cnt != 1 || clr_cnt != 1) begin
      n_err++;
      $display("FAIL %s_counts: busy=%0d done=%0d clear=%0d, required 16/1/1",
               tag, busy_cnt, done_cnt, clr_cnt);
    end
    n_vec++;
    if (qa.size() != 2 || qb.size() != 2) begin
      n_err++; $display("FAIL %s_feed_count: got %0d/%0d, required 2", tag, qa.size(), qb.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_vec++;
        if (qa[i] != ea[i] || qb[i] != ea[i]) begin
          n_err++;
          $display("FAIL %s_ab_index[%0d]: A=%0d B=%0d, required %0d", tag, i, qa[i], qb[i], ea[i]);
        end
      end
    end
    n_vec++;
    if (qc.size() != 4) begin
      n_err++; $display("FAIL %s_c_writes: got %0d, required 4", tag, qc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (qc[i] != i || qrs[i] != i) begin
          n_err++;
          $display("FAIL %s_c_write[%0d]: C_index=%0d row_sel=%0d, required %0d/%0d",
                   tag, i, qc[i], qrs[i], i, i);
        end
      end
    end
    n_vec++;
    if (perf_at_done !== PERF_S1) begin
      n_err++; $display("FAIL %s_perf: got %0d, required %0d", tag, perf_at_done, PERF_S1);
    end
  endtask

  task automatic test_multi_tile();
    int ea[12] = '{0,1,2, 0,1,2, 3,4,5, 3,4,5};
    int eb[12] = '{0,1,2, 3,4,5, 0,1,2, 3,4,5};
    int ec[10] = '{0,1,2,3, 5,6,7,8, 4, 9};
    int er[10] = '{0,1,2,3, 0,1,2,3, 0, 0};
    run_job(8'd3, 8'd5, 8'd8, -1);
    n_vec++;
    if (busy_cnt != 68 || done_idx != 68 || done_cnt != 1 || clr_cnt != 4) begin
      n_err++;
      $display("FAIL multi_counts: busy=%0d done_idx=%0d done=%0d clear=%0d, required 68/68/1/4",
               busy_cnt, done_idx, done_cnt, clr_cnt);
    end
    n_vec++;
    if (qa.size() != 12) begin
      n_err++; $display("FAIL multi_feed_count: got %0d, required 12", qa.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        n_vec++;
        if (qa[i] != ea[i] || qb[i] != eb[i]) begin
          n_err++;
          $display("FAIL multi_ab_index[%0d]: A=%0d B=%0d, required %0d/%0d",
                   i, qa[i], qb[i], ea[i], eb[i]);
        end
      end
    end
    n_vec++;
    if (qc.size() != 10) begin
      n_err++; $display("FAIL multi_c_writes: got %0d, required 10", qc.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        n_vec++;
        if (qc[i] != ec[i] || qrs[i] != er[i]) begin
          n_err++;
          $display("FAIL multi_c_write[%0d]: C_index=%0d row_sel=%0d, required %0d/%0d",
                   i, qc[i], qrs[i], ec[i], er[i]);
        end
      end
    end
    n_vec++;
    if (perf_at_done !== PERF_S2 || perf_end !== PERF_S2) begin
      n_err++;
      $display("FAIL multi_perf: at_done=%0d later=%0d, required %0d", perf_at_done, perf_end, PERF_S2);
    end
  endtask

  task automatic test_zero_k();
    run_job(8'd0, 8'd4, 8'd4, -1);
    n_vec++;
    if (done_idx != 0 || done_cnt != 1) begin
      n_err++; $display("FAIL zero_done: idx=%0d count=%0d, required 0/1", done_idx, done_cnt);
    end
    n_vec++;
    if (busy_cnt != 0 || qa.size() != 0 || qc.size() != 0 || clr_cnt != 0) begin
      n_err++;
      $display("FAIL zero_activity: busy=%0d feeds=%0d writes=%0d clear=%0d, required 0",
               busy_cnt, qa.size(), qc.size(), clr_cnt);
    end
    n_vec++;
    if (perf_end !== 32'd0) begin
      n_err++; $display("FAIL zero_perf: got %0d, required 0", perf_end);
    end
  endtask

  task automatic test_reset_mid_job();
    int wr_seen, busy_seen;
    @(negedge clk);
    K = 8'd2; M = 8'd4; N = 8'd4; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;          // CLEAR visible
    @(negedge clk);           // FEED visible
    n_vec++;
    if (A_index !== 16'd0 || busy !== 1'b1) begin
      n_err++; $display("FAIL rst_pre_feed: busy=%b A=%0d, required 1/0", busy, A_index);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({busy, done, arr_clear, arr_feed, C_wr_en, arr_row_sel} !== 7'd0 ||
        A_index !== 16'd0 || B_index !== 16'd0 || C_index !== 16'd0 ||
        perf_cycles !== 32'd0) begin
      n_err++;
      $display("FAIL rst_mid_outputs: busy=%b feed=%b A=%0d C=%0d perf=%0d, required all 0",
               busy, arr_feed, A_index, C_index, perf_cycles);
    end
    rst_n = 1'b1;
    wr_seen = 0; busy_seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (C_wr_en) wr_seen++;
      if (busy || done) busy_seen++;
    end
    n_vec++;
    if (wr_seen != 0 || busy_seen != 0) begin
      n_err++; $display("FAIL rst_quiet: writes=%0d busy/done=%0d, required 0/0", wr_seen, busy_seen);
    end
  endtask

  initial begin
    test_reset();
    test_single_tile(-1, "single");
    test_multi_tile();
    test_zero_k();
    test_single_tile(1, "ignore_in_valid");
    test_reset_mid_job();
    test_single_tile(-1, "after_reset");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
